// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the memory initiator: register and memory-port
// types, enable levels, FSM state encoding and the wait-counter width helper.
package mem_initiator_pkg;

   localparam int RegWidth     = 32;
   localparam int MemAddrWidth = 6;

   typedef logic [RegWidth-1:0] Register;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Word memory request: full byte address, the memory decodes the word index
   typedef struct packed {
      logic [31:0] addr;
      logic        read;
      logic        write;
      Register     val;
   } M_input;

   // Word memory response, returned combinationally
   typedef struct packed {
      Register val;
   } M_output;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mi_state_e;

   // Wait counter must hold WAIT_CYCLES and is never narrower than one bit
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Core request/response channel plus word-memory port of the initiator.
// slave  : the initiator's view (accepts core requests, drives the memory).
// master : the environment's view (core driving requests, memory responding).
interface mem_initiator_if
   import mem_initiator_pkg::*;
();

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   Register     req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   Register     rsp_rdata;
   logic        rsp_err;

   M_input      mem_req;
   M_output     mem_rsp;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rsp,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rsp,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req
   );

endinterface

// File: rtl/mem_initiator.sv
// Single-request memory initiator: accepts one core load/store, runs it
// against a word memory with WAIT_CYCLES extra access cycles, and holds the
// response until the core takes it.
// Optional build macro MEM_INITIATOR_ALIGN_CHECK_EN: reject misaligned
// addresses with rsp_err instead of touching memory.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; latches it on handshake
// ACCESS | drives the memory; wait counter runs down to 0
// RESP   | response registered; rsp_valid held until rsp_ready
module mem_initiator
   import mem_initiator_pkg::*;
#(
   parameter int WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_initiator_if.slave  bus_io
);

   localparam int               CntW    = cnt_width(WAIT_CYCLES);
   localparam logic [CntW-1:0]  CntLoad = CntW'(WAIT_CYCLES);

   mi_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            write_q, write_d;
   logic [31:0]     addr_q, addr_d;
   Register         wdata_q, wdata_d;
   Register         rdata_q, rdata_d;
   logic            rsp_valid_q, rsp_valid_d;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
   logic            err_q, err_d;
`endif

   logic            req_ready_c;
   logic            mem_read_c;
   logic            mem_write_c;

   // State and datapath registers; reset drops any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   // Next-state, counter and memory-enable decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = rsp_valid_q;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
      err_d       = err_q;
`endif
      req_ready_c = 1'b0;
      mem_read_c  = DISABLE;
      mem_write_c = DISABLE;

      unique case (state_q)
         IDLE: begin
            req_ready_c = 1'b1;
            if (bus_io.req_valid) begin
               write_d = bus_io.req_write;
               addr_d  = bus_io.req_addr;
               wdata_d = bus_io.req_wdata;
               cnt_d   = CntLoad;
               // stores and errors report zero data
               rdata_d = '0;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
               err_d   = 1'b0;
               if (bus_io.req_addr[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = ACCESS;
               end
`else
               state_d = ACCESS;
`endif
            end
         end

         ACCESS: begin
            mem_read_c = write_q ? DISABLE : ENABLE;
            if (cnt_q == '0) begin
               // store commits on exactly this one edge
               mem_write_c = write_q ? ENABLE : DISABLE;
               if (!write_q) begin
                  rdata_d = bus_io.mem_rsp.val;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RESP: begin
            // rsp_valid rises one cycle after entering RESP
            rsp_valid_d = 1'b1;
            if (rsp_valid_q && bus_io.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus_io.req_ready = req_ready_c;
   assign bus_io.rsp_valid = rsp_valid_q;
   assign bus_io.rsp_rdata = rdata_q;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
   assign bus_io.rsp_err   = err_q;
`else
   assign bus_io.rsp_err   = 1'b0;
`endif

   // Address and data hold their latched values outside ACCESS
   assign bus_io.mem_req = '{addr:  addr_q,
                             read:  mem_read_c,
                             write: mem_write_c,
                             val:   wdata_q};

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: two instances (WAIT_CYCLES 0 and 3), each with its
// own word memory, checked against an address-keyed reference of memory
// contents and the expected handshake timing.
module tb_mem_initiator;
   import mem_initiator_pkg::*;

   localparam int NW = 2 ** MemAddrWidth;
   localparam int W0 = 0;
   localparam int W3 = 3;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        d_valid;
   logic        d_write;
   logic [31:0] d_addr;
   Register     d_wdata;
   logic        d_rready;

   int checks   = 0;
   int failures = 0;

   mem_initiator_if bus0 ();
   mem_initiator_if bus3 ();

   mem_initiator #(.WAIT_CYCLES(W0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus_io(bus0));
   mem_initiator #(.WAIT_CYCLES(W3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus_io(bus3));

   assign bus0.req_valid = d_valid & ~sel;
   assign bus3.req_valid = d_valid & sel;
   assign bus0.req_write = d_write;
   assign bus3.req_write = d_write;
   assign bus0.req_addr  = d_addr;
   assign bus3.req_addr  = d_addr;
   assign bus0.req_wdata = d_wdata;
   assign bus3.req_wdata = d_wdata;
   assign bus0.rsp_ready = d_rready & ~sel;
   assign bus3.rsp_ready = d_rready & sel;

   // word memories: low two address bits dropped, upper bits aliased
   Register mem0 [NW] = '{default: '0};
   Register mem3 [NW] = '{default: '0};

   function automatic int widx(input logic [31:0] a);
      return int'(a[MemAddrWidth+1:2]);
   endfunction

   assign bus0.mem_rsp = '{val: mem0[widx(bus0.mem_req.addr)]};
   assign bus3.mem_rsp = '{val: mem3[widx(bus3.mem_req.addr)]};

   always @(posedge clk) begin
      if (bus0.mem_req.write) mem0[widx(bus0.mem_req.addr)] <= bus0.mem_req.val;
      if (bus3.mem_req.write) mem3[widx(bus3.mem_req.addr)] <= bus3.mem_req.val;
   end

   // observation of the selected instance
   logic    o_req_ready;
   logic    o_rsp_valid;
   logic    o_err;
   Register o_rdata;
   M_input  o_mem;
   always_comb begin
      o_req_ready = bus0.req_ready;
      o_rsp_valid = bus0.rsp_valid;
      o_err       = bus0.rsp_err;
      o_rdata     = bus0.rsp_rdata;
      o_mem       = bus0.mem_req;
      if (sel) begin
         o_req_ready = bus3.req_ready;
         o_rsp_valid = bus3.rsp_valid;
         o_err       = bus3.rsp_err;
         o_rdata     = bus3.rsp_rdata;
         o_mem       = bus3.mem_req;
      end
   end

   // reference: contents per instance, keyed by word number modulo memory size
   Register ref0 [int unsigned];
   Register ref3 [int unsigned];

   function automatic int unsigned ref_key(input logic [31:0] a);
      return (a / 4) % NW;
   endfunction

   function automatic Register ref_read(input logic s, input logic [31:0] a);
      int unsigned k;
      k = ref_key(a);
      if (s) return ref3.exists(k) ? ref3[k] : '0;
      return ref0.exists(k) ? ref0[k] : '0;
   endfunction

   function automatic bit exp_err(input logic [31:0] a);
      return ALIGN && ((a % 4) != 0);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic noise();
      d_valid = 1'($urandom);
      d_write = 1'($urandom);
      d_addr  = $urandom;
      d_wdata = $urandom;
   endtask

   task automatic check_reset_state(input logic s);
      sel = s;
      #1;
      check("rst_req_ready", o_req_ready, 1);
      check("rst_rsp_valid", o_rsp_valid, 0);
      check("rst_rsp_err",   o_err, 0);
      check("rst_rsp_rdata", o_rdata, 0);
      check("rst_mem_addr",  o_mem.addr, 0);
      check("rst_mem_val",   o_mem.val, 0);
      check("rst_mem_en",    {o_mem.read, o_mem.write}, 0);
   endtask

   // One transaction, entered and left just after a falling edge
   task automatic do_op(input logic s, input logic wr, input logic [31:0] a,
                        input Register wd, input int hold);
      int          lat, n_rd, n_wr, wc;
      logic        misal, done, timed_out;
      logic [31:0] seen_addr;
      Register     seen_val, exp_rd;
      wc        = s ? W3 : W0;
      misal     = exp_err(a);
      seen_addr = '0;
      seen_val  = '0;
      sel       = s;
      d_valid   = 1'b1;
      d_write   = wr;
      d_addr    = a;
      d_wdata   = wd;
      d_rready  = 1'b0;
      #1 check("req_ready_idle", o_req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      lat = 0; n_rd = 0; n_wr = 0; done = 1'b0; timed_out = 1'b0;
      while (!done) begin
         if (o_rsp_valid) begin
            done = 1'b1;
         end else if (lat >= 40) begin
            done = 1'b1;
            timed_out = 1'b1;
         end else begin
            if (o_mem.read) n_rd++;
            if (o_mem.write) begin
               n_wr++;
               seen_addr = o_mem.addr;
               seen_val  = o_mem.val;
            end
            noise();
            @(negedge clk);
            lat++;
         end
      end
      check("rsp_latency", lat, misal ? 1 : wc + 2);
      if (timed_out) begin
         d_valid = 1'b0;
         return;
      end
      check("read_cycles",  n_rd, (wr || misal) ? 0 : wc + 1);
      check("write_cycles", n_wr, (!wr || misal) ? 0 : 1);
      if (n_wr == 1) begin
         check("commit_addr", seen_addr, a);
         check("commit_val",  seen_val, wd);
      end
      exp_rd = (wr || misal) ? '0 : ref_read(s, a);
      check("rsp_rdata", o_rdata, exp_rd);
      check("rsp_err",   o_err, misal);
      if (wr && !misal) begin
         if (s) ref3[ref_key(a)] = wd;
         else   ref0[ref_key(a)] = wd;
      end
      for (int i = 0; i < hold; i++) begin
         noise();
         @(negedge clk);
         check("hold_rsp_valid", o_rsp_valid, 1);
         check("hold_rsp_rdata", o_rdata, exp_rd);
         check("hold_req_ready", o_req_ready, 0);
         check("hold_mem_en",    {o_mem.read, o_mem.write}, 0);
      end
      d_valid  = 1'b0;
      d_rready = 1'b1;
      @(negedge clk);
      d_rready = 1'b0;
      check("idle_after_rsp", o_req_ready, 1);
      check("rsp_valid_drop", o_rsp_valid, 0);
   endtask

   logic [31:0] ra;

   initial begin
      rst_n    = 1'b1;
      sel      = 1'b0;
      d_valid  = 1'b0;
      d_write  = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      d_rready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state(1'b0);
      check_reset_state(1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // zero wait: store then load back, two cycles each
      do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
      do_op(1'b0, 1'b0, 32'h10, 32'h0, 0);
      check("w0_load_value", o_rdata, 32'hDEAD_BEEF);

      // three waits: single commit edge, five-cycle response
      do_op(1'b1, 1'b1, 32'h20, 32'hA5A5_0F0F, 0);

      // response back-pressure for six cycles
      do_op(1'b1, 1'b0, 32'h20, 32'h0, 6);

      // misaligned load after a known store
      do_op(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 0);
      do_op(1'b0, 1'b0, 32'h13, 32'h0, 0);

      // reset in the second access cycle of a store aborts the commit
      do_op(1'b1, 1'b1, 32'h30, 32'h0, 0);
      sel     = 1'b1;
      d_valid = 1'b1;
      d_write = 1'b1;
      d_addr  = 32'h30;
      d_wdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      d_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", o_rsp_valid, 0);
      check("abort_mem_en",    {o_mem.read, o_mem.write}, 0);
      check("abort_mem_addr",  o_mem.addr, 0);
      check("abort_mem_val",   o_mem.val, 0);
      check("abort_req_ready", o_req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      check("abort_no_commit", mem3[12], 0);
      rst_n = 1'b1;
      do_op(1'b1, 1'b0, 32'h30, 32'h0, 0);

      // randomized traffic, upper address bits exercise aliasing
      for (int i = 0; i < 60; i++) begin
         ra = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom);
         do_op(1'($urandom), 1'($urandom), ra, $urandom, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
